// File: rtl/axi_lite_arb2_if.sv
// AXI-lite bus bundle shared by the two upstream masters and the downstream bridge port.
// Every channel moves one beat on a cycle where valid and ready are both high; valid and payload stay stable until then.
interface axi_lite_arb2_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic                    bvalid;
  logic [1:0]              bresp;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_arb2.sv
// Two-master / one-slave AXI-lite arbiter, one transaction in flight, writes served before reads.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between masters; otherwise m1 always wins a tie.
module axi_lite_arb2 #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  axi_lite_arb2_if.slave   m0,
  axi_lite_arb2_if.slave   m1,
  axi_lite_arb2_if.master  s,
  output logic [2:0]       debug_arb_state,
  output logic             debug_grant
);

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_WADDR = 3'b001;
  localparam logic [2:0] ST_RADDR = 3'b010;
  localparam logic [2:0] ST_WRESP = 3'b011;
  localparam logic [2:0] ST_RDATA = 3'b100;

  logic [2:0] state, state_next;
  logic       grant, grant_next;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_grant;
`endif

  logic wreq0, wreq1, req0, req1;
  logic pick, pick_write;

  assign wreq0 = m0.awvalid & m0.wvalid;
  assign wreq1 = m1.awvalid & m1.wvalid;
  assign req0  = wreq0 | m0.arvalid;
  assign req1  = wreq1 | m1.arvalid;

  always_comb begin
    pick = req1;
    if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick = ~last_grant;
`else
      pick = 1'b1;
`endif
    end
    pick_write = pick ? wreq1 : wreq0;
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_next = pick;
          state_next = pick_write ? ST_WADDR : ST_RADDR;
        end
      end
      ST_WADDR: if (s.awready && s.wready) state_next = ST_WRESP;
      ST_WRESP: if (s.bvalid && s.bready) state_next = ST_IDLE;
      ST_RADDR: if (s.arready) state_next = ST_RDATA;
      ST_RDATA: if (s.rvalid && s.rready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      grant <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_next;
      grant <= grant_next;
`ifdef ARB_ROUND_ROBIN_EN
      // Remember the winner only once its response has completed.
      if ((state == ST_WRESP && s.bvalid && s.bready) ||
          (state == ST_RDATA && s.rvalid && s.rready))
        last_grant <= grant;
`endif
    end
  end

  logic in_waddr, in_wresp, in_raddr, in_rdata;
  assign in_waddr = (state == ST_WADDR);
  assign in_wresp = (state == ST_WRESP);
  assign in_raddr = (state == ST_RADDR);
  assign in_rdata = (state == ST_RDATA);

  logic [ADDR_WIDTH-1:0]   g_awaddr, g_araddr;
  logic [DATA_WIDTH-1:0]   g_wdata;
  logic [DATA_WIDTH/8-1:0] g_wstrb;
  logic                    g_bready, g_rready;

  assign g_awaddr = grant ? m1.awaddr : m0.awaddr;
  assign g_wdata  = grant ? m1.wdata  : m0.wdata;
  assign g_wstrb  = grant ? m1.wstrb  : m0.wstrb;
  assign g_bready = grant ? m1.bready : m0.bready;
  assign g_araddr = grant ? m1.araddr : m0.araddr;
  assign g_rready = grant ? m1.rready : m0.rready;

  // Downstream side: each channel is driven only in the state that owns it.
  assign s.awvalid = in_waddr;
  assign s.wvalid  = in_waddr;
  assign s.awaddr  = in_waddr ? g_awaddr : '0;
  assign s.wdata   = in_waddr ? g_wdata  : '0;
  assign s.wstrb   = in_waddr ? g_wstrb  : '0;
  assign s.bready  = in_wresp & g_bready;
  assign s.arvalid = in_raddr;
  assign s.araddr  = in_raddr ? g_araddr : '0;
  assign s.rready  = in_rdata & g_rready;

  logic sel0, sel1;
  assign sel0 = ~grant;
  assign sel1 = grant;

  assign m0.awready = in_waddr & sel0 & s.awready;
  assign m0.wready  = in_waddr & sel0 & s.wready;
  assign m0.bvalid  = in_wresp & sel0 & s.bvalid;
  assign m0.bresp   = (in_wresp & sel0) ? s.bresp : 2'b00;
  assign m0.arready = in_raddr & sel0 & s.arready;
  assign m0.rvalid  = in_rdata & sel0 & s.rvalid;
  assign m0.rdata   = (in_rdata & sel0) ? s.rdata : '0;
  assign m0.rresp   = (in_rdata & sel0) ? s.rresp : 2'b00;

  assign m1.awready = in_waddr & sel1 & s.awready;
  assign m1.wready  = in_waddr & sel1 & s.wready;
  assign m1.bvalid  = in_wresp & sel1 & s.bvalid;
  assign m1.bresp   = (in_wresp & sel1) ? s.bresp : 2'b00;
  assign m1.arready = in_raddr & sel1 & s.arready;
  assign m1.rvalid  = in_rdata & sel1 & s.rvalid;
  assign m1.rdata   = (in_rdata & sel1) ? s.rdata : '0;
  assign m1.rresp   = (in_rdata & sel1) ? s.rresp : 2'b00;

  assign debug_arb_state = state;
  assign debug_grant     = grant;

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2: arbitration vector table plus hand-written multi-cycle sequences.
module tb_axi_lite_arb2;
  logic       clk;
  logic       rstn;
  logic [2:0] debug_arb_state;
  logic       debug_grant;

  axi_lite_arb2_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m0_bus ();
  axi_lite_arb2_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m1_bus ();
  axi_lite_arb2_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) s_bus ();

  axi_lite_arb2 #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .m0              (m0_bus),
    .m1              (m1_bus),
    .s               (s_bus),
    .debug_arb_state (debug_arb_state),
    .debug_grant     (debug_grant)
  );

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic TIE_G = 1'b0;
`else
  localparam logic TIE_G = 1'b1;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [63:0] mem_word = '0;

  typedef struct {
    logic       m0_aw, m0_w, m0_ar;
    logic       m1_aw, m1_w, m1_ar;
    logic [2:0] st;
    logic       g;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_bus.awaddr = '0; m0_bus.awvalid = 0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
    m0_bus.wvalid = 0;  m0_bus.bready = 0;  m0_bus.araddr = '0; m0_bus.arvalid = 0;
    m0_bus.rready = 0;
    m1_bus.awaddr = '0; m1_bus.awvalid = 0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
    m1_bus.wvalid = 0;  m1_bus.bready = 0;  m1_bus.araddr = '0; m1_bus.arvalid = 0;
    m1_bus.rready = 0;
    s_bus.awready = 0; s_bus.wready = 0; s_bus.bvalid = 0; s_bus.bresp = '0;
    s_bus.arready = 0; s_bus.rvalid = 0; s_bus.rdata = '0; s_bus.rresp = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    step();
    rstn = 1'b1;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, " state"}, 64'(debug_arb_state), 64'd0);
    chk({tag, " grant"}, 64'(debug_grant), 64'd0);
    chk({tag, " s valids"}, 64'({s_bus.awvalid, s_bus.wvalid, s_bus.arvalid, s_bus.bready, s_bus.rready}), 64'd0);
    chk({tag, " m0 hs"}, 64'({m0_bus.awready, m0_bus.wready, m0_bus.bvalid, m0_bus.arready, m0_bus.rvalid}), 64'd0);
    chk({tag, " m1 hs"}, 64'({m1_bus.awready, m1_bus.wready, m1_bus.bvalid, m1_bus.arready, m1_bus.rvalid}), 64'd0);
  endtask

  // Bridge model for a read: wait for RADDR, accept, return data, complete.
  task automatic serve_read(input string name, input logic [63:0] exp_addr, input logic exp_g);
    int n;
    n = 0;
    while (debug_arb_state != 3'b010 && n < 10) begin
      step();
      n++;
    end
    if (n >= 10) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: state %b never reached 010", name, debug_arb_state);
    end else begin
      chk({name, " araddr"}, s_bus.araddr, exp_addr);
      chk({name, " grant"}, 64'(debug_grant), 64'(exp_g));
      s_bus.arready = 1'b1;
      step();
      s_bus.arready = 1'b0;
      s_bus.rvalid  = 1'b1;
      s_bus.rdata   = exp_addr;
      step();
      s_bus.rvalid  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, TIE_G};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, TIE_G ? 3'b010 : 3'b001, TIE_G};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, TIE_G ? 3'b001 : 3'b010, TIE_G};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0};

    // reset state
    rstn = 1'b0;
    clear_inputs();
    step();
    step();
    chk_all_quiet("reset");
    rstn = 1'b1;

    // arbitration table: one IDLE decision per vector from a fresh reset
    for (int i = 0; i < 11; i++) begin
      do_reset();
      m0_bus.awvalid = vecs[i].m0_aw; m0_bus.wvalid = vecs[i].m0_w; m0_bus.arvalid = vecs[i].m0_ar;
      m1_bus.awvalid = vecs[i].m1_aw; m1_bus.wvalid = vecs[i].m1_w; m1_bus.arvalid = vecs[i].m1_ar;
      m0_bus.araddr = 64'h100; m1_bus.araddr = 64'h200;
      m0_bus.awaddr = 64'h10;  m1_bus.awaddr = 64'h20;
      #1;
      chk($sformatf("vec%0d pre s_arvalid", i), 64'(s_bus.arvalid), 64'd0);
      step();
      chk($sformatf("vec%0d state", i), 64'(debug_arb_state), 64'(vecs[i].st));
      chk($sformatf("vec%0d grant", i), 64'(debug_grant), 64'(vecs[i].g));
      chk($sformatf("vec%0d s_awvalid", i), 64'(s_bus.awvalid), 64'(vecs[i].st == 3'b001));
      chk($sformatf("vec%0d s_arvalid", i), 64'(s_bus.arvalid), 64'(vecs[i].st == 3'b010));
      if (vecs[i].st == 3'b010)
        chk($sformatf("vec%0d s_araddr", i), s_bus.araddr, vecs[i].g ? 64'h200 : 64'h100);
      if (vecs[i].st == 3'b001)
        chk($sformatf("vec%0d s_awaddr", i), s_bus.awaddr, vecs[i].g ? 64'h20 : 64'h10);
    end

    // single m0 read
    do_reset();
    m0_bus.araddr = 64'h80; m0_bus.arvalid = 1'b1;
    step();
    chk("rd0 s_arvalid", 64'(s_bus.arvalid), 64'd1);
    chk("rd0 s_araddr", s_bus.araddr, 64'h80);
    s_bus.arready = 1'b1;
    #1;
    chk("rd0 m0_arready", 64'(m0_bus.arready), 64'd1);
    chk("rd0 m1_arready", 64'(m1_bus.arready), 64'd0);
    step();
    m0_bus.arvalid = 1'b0; m0_bus.rready = 1'b1;
    s_bus.arready = 1'b0; s_bus.rvalid = 1'b1; s_bus.rdata = 64'hDEADBEEF_CAFEF00D; s_bus.rresp = 2'b00;
    #1;
    chk("rd0 state", 64'(debug_arb_state), 64'b100);
    chk("rd0 m0_rvalid", 64'(m0_bus.rvalid), 64'd1);
    chk("rd0 m0_rdata", m0_bus.rdata, 64'hDEADBEEF_CAFEF00D);
    chk("rd0 m0_rresp", 64'(m0_bus.rresp), 64'd0);
    chk("rd0 s_rready", 64'(s_bus.rready), 64'd1);
    chk("rd0 m1 quiet", 64'({m1_bus.rvalid, m1_bus.arready, m1_bus.bvalid}), 64'd0);
    chk("rd0 m1_rdata", m1_bus.rdata, 64'd0);
    step();
    s_bus.rvalid = 1'b0;
    #1;
    chk("rd0 back idle", 64'(debug_arb_state), 64'd0);

    // m1 write and read to the same address presented together
    do_reset();
    m1_bus.awaddr = 64'h40; m1_bus.wdata = 64'h11223344_55667788; m1_bus.wstrb = 8'h0F;
    m1_bus.awvalid = 1'b1; m1_bus.wvalid = 1'b1; m1_bus.araddr = 64'h40; m1_bus.arvalid = 1'b1;
    m1_bus.bready = 1'b1; m1_bus.rready = 1'b1;
    step();
    chk("wr1 state", 64'(debug_arb_state), 64'b001);
    chk("wr1 grant", 64'(debug_grant), 64'd1);
    chk("wr1 s_arvalid", 64'(s_bus.arvalid), 64'd0);
    chk("wr1 s_wvalid", 64'(s_bus.wvalid), 64'd1);
    chk("wr1 s_awaddr", s_bus.awaddr, 64'h40);
    chk("wr1 s_wstrb", 64'(s_bus.wstrb), 64'h0F);
    s_bus.awready = 1'b1; s_bus.wready = 1'b1;
    #1;
    chk("wr1 m1 ready", 64'({m1_bus.awready, m1_bus.wready}), 64'b11);
    for (int b = 0; b < 8; b++)
      if (s_bus.wstrb[b]) mem_word[b*8 +: 8] = s_bus.wdata[b*8 +: 8];
    step();
    m1_bus.awvalid = 1'b0; m1_bus.wvalid = 1'b0;
    s_bus.awready = 1'b0; s_bus.wready = 1'b0; s_bus.bvalid = 1'b1; s_bus.bresp = 2'b00;
    #1;
    chk("wr1 wresp state", 64'(debug_arb_state), 64'b011);
    chk("wr1 m1_bvalid", 64'(m1_bus.bvalid), 64'd1);
    chk("wr1 m1_bresp", 64'(m1_bus.bresp), 64'd0);
    chk("wr1 s_bready", 64'(s_bus.bready), 64'd1);
    chk("wr1 s_arvalid in wresp", 64'(s_bus.arvalid), 64'd0);
    step();
    s_bus.bvalid = 1'b0;
    #1;
    chk("wr1 s_arvalid in idle", 64'(s_bus.arvalid), 64'd0);
    step();
    chk("rd1 s_arvalid", 64'(s_bus.arvalid), 64'd1);
    chk("rd1 s_araddr", s_bus.araddr, 64'h40);
    s_bus.arready = 1'b1;
    step();
    m1_bus.arvalid = 1'b0;
    s_bus.arready = 1'b0; s_bus.rvalid = 1'b1; s_bus.rdata = mem_word;
    #1;
    chk("rd1 m1_rdata", m1_bus.rdata, 64'h00000000_55667788);
    step();
    s_bus.rvalid = 1'b0;

    // m1 stalls its write response while m0 waits with a read
    do_reset();
    m1_bus.awaddr = 64'h80; m1_bus.wdata = 64'h1; m1_bus.wstrb = 8'hFF;
    m1_bus.awvalid = 1'b1; m1_bus.wvalid = 1'b1;
    step();
    chk("stall grant", 64'(debug_grant), 64'd1);
    m0_bus.araddr = 64'h300; m0_bus.arvalid = 1'b1;
    s_bus.awready = 1'b1; s_bus.wready = 1'b1;
    step();
    m1_bus.awvalid = 1'b0; m1_bus.wvalid = 1'b0;
    s_bus.awready = 1'b0; s_bus.wready = 1'b0; s_bus.bvalid = 1'b1; m1_bus.bready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall c%0d state", c), 64'(debug_arb_state), 64'b011);
      chk($sformatf("stall c%0d m0_arready", c), 64'(m0_bus.arready), 64'd0);
      chk($sformatf("stall c%0d s_bready", c), 64'(s_bus.bready), 64'd0);
      step();
    end
    m1_bus.bready = 1'b1;
    #1;
    chk("stall b handshake", 64'({m1_bus.bvalid, s_bus.bready}), 64'b11);
    step();
    s_bus.bvalid = 1'b0; m1_bus.bready = 1'b0;
    #1;
    chk("stall idle", 64'(debug_arb_state), 64'd0);
    chk("stall idle s_arvalid", 64'(s_bus.arvalid), 64'd0);
    step();
    chk("stall m0 state", 64'(debug_arb_state), 64'b010);
    chk("stall m0 grant", 64'(debug_grant), 64'd0);
    chk("stall m0 araddr", s_bus.araddr, 64'h300);

    // reset pulsed while in RDATA
    s_bus.arready = 1'b1;
    step();
    s_bus.arready = 1'b0; s_bus.rvalid = 1'b1; s_bus.rdata = 64'h55;
    m0_bus.arvalid = 1'b0; m0_bus.rready = 1'b0;
    #1;
    chk("rst mid state", 64'(debug_arb_state), 64'b100);
    chk("rst mid m0_rvalid", 64'(m0_bus.rvalid), 64'd1);
    rstn = 1'b0;
    step();
    chk_all_quiet("rst mid");
    chk("rst mid m0_rdata", m0_bus.rdata, 64'd0);
    rstn = 1'b1;
    clear_inputs();

    // both masters keep requesting reads
    do_reset();
    m0_bus.araddr = 64'h100; m0_bus.arvalid = 1'b1; m0_bus.rready = 1'b1;
    m1_bus.araddr = 64'h200; m1_bus.arvalid = 1'b1; m1_bus.rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      serve_read($sformatf("cont%0d", k), (k % 2 == 0) ? 64'h100 : 64'h200, (k % 2 == 1));
`else
      serve_read($sformatf("cont%0d", k), 64'h200, 1'b1);
`endif
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
